subbyte_iter: RTL and testbench
===============================

Name: subbyte_iter

Overview:
Iterative, parametrised AES SubBytes engine for the 128-bit state. It uses NUM_SBOX byte-substitution lanes, so one state is processed in 16/NUM_SBOX cycles. This lets the area/latency trade-off be chosen per instance. It sits between the round-key XOR and ShiftRows stages of the round datapath, with valid/ready handshakes on both sides, and supports forward or inverse substitution per transaction.

Parameters:
NUM_SBOX, 4, number of parallel byte lanes; legal values 1, 2, 4, 8, 16; any other value raises an elaboration $error.
ITER, 16/NUM_SBOX (derived localparam, not overridable), cycles per state.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream presents a state
in_ready  out  1  engine can accept a state this cycle
in_data  in  128  state; byte i = in_data[8i+7:8i]
in_inv  in  1  1 = inverse S-box, 0 = forward; sampled with in_data
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_data  out  128  substituted state, same byte ordering

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state is updated on the rising edge of clk.
- FSM states: IDLE, BUSY, DONE. A transfer occurs on any edge where valid && ready.
- Reset values: state = IDLE, out_valid = 0, out_data = 0, lane counter = 0, in_ready = 1 in the cycle after reset.
- in_ready = (state == IDLE) || (state == DONE && out_ready). It is combinational and never depends on in_valid.
- Accept (IDLE or DONE with out_ready):
  - Latch in_data into the working register and in_inv into the mode flag.
  - Clear the counter to 0 and go to BUSY.
- BUSY, counter = k:
  - Lanes j = 0..NUM_SBOX-1 replace working byte k*NUM_SBOX + j with S(byte) or S⁻¹(byte), per the mode flag.
  - Increment k.
  - When k == ITER-1, go to DONE in the same edge.
- Counter width is max(1, $clog2(ITER)). It never wraps past ITER-1.
- DONE:
  - out_valid = 1 and out_data = working register.
  - Both are held stable until out_ready.
  - out_ready with no new accept → IDLE, out_valid drops.
  - out_ready together with in_valid → accept directly and go to BUSY (back-to-back). out_valid drops for at least 1 cycle.
- Latency: out_valid rises exactly ITER cycles after the accept edge. For NUM_SBOX = 16, that is the edge following accept.
- Throughput: one state per ITER+1 cycles with continuous handshakes.
- The input is ignored while in BUSY; in_data may change freely during that time.
- Reset mid-operation (BUSY or DONE): the state is abandoned with no output. Reset values are restored on the next edge.
- out_data changes only on the DONE-entry edge or on reset. It is not updated byte-by-byte while in BUSY.

Optional Feature:
SUBBYTE_INV_EN
- Defined: the inverse S-box table is compiled into every lane, and in_inv selects the direction.
- Undefined:
  - The inverse table is not instantiated.
  - in_inv and the mode flag are ignored, and every transaction uses the forward S-box.
  - Lane area is roughly halved.

Decomposition:
- aes_pkg holds:
  - SBOX and INV_SBOX as 256×8-bit constant arrays (FIPS-197);
  - the subbyte_state_t enum {IDLE, BUSY, DONE};
  - the BYTES_PER_STATE = 16 constant.
- One sub-module, sbox_lane: a combinational byte lookup (byte_in, inv, byte_out), instantiated NUM_SBOX times through generate. Its inverse path exists only under SUBBYTE_INV_EN.
- The FSM, counter and working register stay in subbyte_iter.

Test Plan:
1. NUM_SBOX = 4, fwd, in_data = all 0x00 → out_data = all 0x63; out_valid rises exactly 4 cycles after accept.
2. NUM_SBOX = 1, fwd, in_data = 128'h00112233445566778899aabbccddeeff → out_data = 128'h638293c31bfc33f5c4eeacea4bc12816, after 16 cycles.
3. With SUBBYTE_INV_EN, in_inv = 1, in_data = all 0x63 → all 0x00. Without the macro, the same stimulus gives all 0xfb (forward S(0x63)).
4. Backpressure: out_ready held 0 for 10 cycles in DONE → out_valid and out_data stable, in_ready = 0. Then out_ready = 1 with in_valid = 1 → back-to-back accept and a second correct result.
5. rst asserted at BUSY counter = 2 → next cycle state = IDLE, out_valid = 0, out_data = 0, in_ready = 1. A fresh transaction then completes normally.
6. NUM_SBOX = 16, random 1000 states with random valid/ready throttling, checked against a scoreboard → 1-cycle latency, no lost or duplicated transfers.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants for the SubBytes engine: FIPS-197 forward/inverse S-boxes,
// FSM state type and state size.
package aes_pkg;

  localparam int BYTES_PER_STATE = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} subbyte_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lane.sv
// One combinational AES byte-substitution lane. The inverse table and the
// direction select exist only when SUBBYTE_INV_EN is defined.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       inv,
  output logic [7:0] byte_out
);

`ifdef SUBBYTE_INV_EN
  assign byte_out = inv ? INV_SBOX[byte_in] : SBOX[byte_in];
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign byte_out   = SBOX[byte_in];
`endif

endmodule

// File: rtl/subbyte_iter.sv
// Iterative AES SubBytes over a 128-bit state, NUM_SBOX bytes per cycle.
// Inverse substitution is available only when SUBBYTE_INV_EN is defined.
module subbyte_iter
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int ITER = BYTES_PER_STATE / NUM_SBOX;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
        NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
    $error("subbyte_iter: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  subbyte_state_t                  state, state_n;
  logic [CW-1:0]                   cnt;
  logic [BYTES_PER_STATE-1:0][7:0] work, work_n;
  logic                            mode;
  logic [3:0]                      base;
  logic [NUM_SBOX-1:0][7:0]        lane_in, lane_out;
  logic                            accept, last;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST);
  assign out_valid = (state == DONE);
  assign base      = 4'(int'(cnt) * NUM_SBOX);

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
    assign lane_in[j] = work[base + 4'(j)];
    sbox_lane u_lane (
      .byte_in  (lane_in[j]),
      .inv      (mode),
      .byte_out (lane_out[j])
    );
  end

  always_comb begin
    work_n = work;
    for (int j = 0; j < NUM_SBOX; j++) work_n[base + 4'(j)] = lane_out[j];
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid) state_n = BUSY;
      BUSY:    if (last) state_n = DONE;
      DONE:    if (out_ready) state_n = in_valid ? BUSY : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // out_data is loaded once with the finished state so it never shows partial bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      mode     <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        work <= in_data;
        mode <= in_inv;
        cnt  <= '0;
      end else if (state == BUSY) begin
        work <= work_n;
        if (last) out_data <= work_n;
        else      cnt      <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_subbyte_iter.sv
// Directed and throttled-random bench for subbyte_iter at NUM_SBOX = 4, 1 and 16.
// Expected values are hand constants or a GF(2^8)-derived S-box model.
module tb_subbyte_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
  logic [127:0] a_in_data, a_out_data;
  logic b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
  logic [127:0] b_in_data, b_out_data;
  logic c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready;
  logic [127:0] c_in_data, c_out_data;

  subbyte_iter #(.NUM_SBOX(4)) dut (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_inv(a_in_inv), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data));
  subbyte_iter #(.NUM_SBOX(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_inv(b_in_inv), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data));
  subbyte_iter #(.NUM_SBOX(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_inv(c_in_inv), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data));

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] VEC_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_CT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic [7:0] m_sbox [256];
  logic [7:0] m_inv  [256];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_model();
    logic [7:0] x, iv, r, s;
    for (int i = 0; i < 256; i++) begin
      x  = 8'(i);
      iv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ 8'h63;
      r = iv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      m_sbox[i] = s;
      m_inv[s]  = x;
    end
  endtask

  function automatic logic [127:0] sub_state(logic [127:0] st, logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
`ifdef SUBBYTE_INV_EN
      r[8*i +: 8] = inv ? m_inv[st[8*i +: 8]] : m_sbox[st[8*i +: 8]];
`else
      r[8*i +: 8] = m_sbox[st[8*i +: 8]];
`endif
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 0; a_in_inv = 0; a_in_data = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_inv = 0; b_in_data = '0; b_out_ready = 1;
    c_in_valid = 0; c_in_inv = 0; c_in_data = '0; c_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    if (a_out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", a_out_data); end
    if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready4: got %b want 1", a_in_ready); end
    if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready1: got %b want 1", b_in_ready); end
    if (c_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid16: got %b want 0", c_out_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fwd_zero();
    int lat = 0;
    a_in_data = '0; a_in_inv = 0; a_in_valid = 1;
    @(posedge clk); #1;
    a_in_valid = 0;
    while (!a_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks += 3;
    if (lat != 4) begin errors++; $display("FAIL zero_latency: got %0d want 4", lat); end
    if (a_out_data !== {16{8'h63}}) begin errors++; $display("FAIL zero_data: got %h want %h", a_out_data, {16{8'h63}}); end
    @(posedge clk); #1;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL zero_release: got valid=%b ready=%b want 0/1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_fwd_vector();
    int lat = 0;
    b_in_data = VEC_PT; b_in_inv = 0; b_in_valid = 1;
    @(posedge clk); #1;
    b_in_valid = 0;
    b_in_data = '1;
    while (!b_out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    checks += 2;
    if (lat != 16) begin errors++; $display("FAIL vec_latency: got %0d want 16", lat); end
    if (b_out_data !== VEC_CT) begin errors++; $display("FAIL vec_data: got %h want %h", b_out_data, VEC_CT); end
    @(posedge clk); #1;
  endtask

  task automatic run_a(input logic [127:0] d, input logic inv, output logic [127:0] res, output int lat);
    lat = 0;
    a_in_data = d; a_in_inv = inv; a_in_valid = 1;
    @(posedge clk); #1;
    a_in_valid = 0; a_in_inv = 0;
    while (!a_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    res = a_out_data;
    @(posedge clk); #1;
  endtask

  task automatic test_inv();
    logic [127:0] res, exp1, exp2;
    int lat;
`ifdef SUBBYTE_INV_EN
    exp1 = '0;
    exp2 = VEC_PT;
`else
    exp1 = {16{8'hfb}};
    exp2 = sub_state(VEC_CT, 1'b0);
`endif
    run_a({16{8'h63}}, 1'b1, res, lat);
    checks += 2;
    if (res !== exp1) begin errors++; $display("FAIL inv_all63: got %h want %h", res, exp1); end
    if (lat != 4) begin errors++; $display("FAIL inv_latency: got %0d want 4", lat); end
    run_a(VEC_CT, 1'b1, res, lat);
    checks++;
    if (res !== exp2) begin errors++; $display("FAIL inv_vector: got %h want %h", res, exp2); end
    run_a(VEC_PT, 1'b0, res, lat);
    checks++;
    if (res !== VEC_CT) begin errors++; $display("FAIL fwd_after_inv: got %h want %h", res, VEC_CT); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    a_out_ready = 0;
    a_in_data = VEC_PT; a_in_inv = 0; a_in_valid = 1;
    @(posedge clk); #1;
    a_in_valid = 0;
    while (!a_out_valid && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (!a_out_valid) begin errors++; $display("FAIL bp_timeout: got no out_valid want 1"); end
    a_in_data = {16{8'h53}}; a_in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      checks += 3;
      if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", a_out_valid); end
      if (a_out_data !== VEC_CT) begin errors++; $display("FAIL bp_hold_data: got %h want %h", a_out_data, VEC_CT); end
      if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", a_in_ready); end
      @(posedge clk); #1;
    end
    a_out_ready = 1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", a_in_ready); end
    @(posedge clk); #1;
    a_in_valid = 0;
    checks++;
    if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b want 0", a_out_valid); end
    n = 0;
    while (!a_out_valid && n < 40) begin @(posedge clk); #1; n++; end
    checks += 2;
    if (n != 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", n); end
    if (a_out_data !== {16{8'hed}}) begin errors++; $display("FAIL b2b_data: got %h want %h", a_out_data, {16{8'hed}}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int lat;
    a_in_data = '0; a_in_inv = 0; a_in_valid = 1;
    @(posedge clk); #1;
    a_in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks += 3;
    if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", a_out_valid); end
    if (a_out_data !== '0) begin errors++; $display("FAIL rstmid_data: got %h want 0", a_out_data); end
    if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", a_in_ready); end
    repeat (6) begin
      @(posedge clk); #1;
      checks++;
      if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_output: got %b want 0", a_out_valid); end
    end
    run_a({16{8'h01}}, 1'b0, res, lat);
    checks += 2;
    if (res !== {16{8'h7c}}) begin errors++; $display("FAIL rstmid_fresh_data: got %h want %h", res, {16{8'h7c}}); end
    if (lat != 4) begin errors++; $display("FAIL rstmid_fresh_latency: got %0d want 4", lat); end
  endtask

  task automatic test_random();
    logic [127:0] q[$];
    logic [127:0] d, e;
    logic iv, fire;
    logic [1:0] hist = 2'b00;
    int sent = 0, recv = 0, cyc = 0;
    d  = {$urandom(), $urandom(), $urandom(), $urandom()};
    iv = 1'($urandom_range(0, 1));
    while ((sent < 1000 || recv < sent) && cyc < 20000) begin
      c_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      c_in_data   = d;
      c_in_inv    = iv;
      c_out_ready = ($urandom_range(0, 3) != 0);
      #2;
      if (hist[0]) begin
        checks++;
        if (c_out_valid !== 1'b0) begin errors++; $display("FAIL rnd_busy_gap: got %b want 0", c_out_valid); end
      end
      if (hist[1]) begin
        checks++;
        if (c_out_valid !== 1'b1) begin errors++; $display("FAIL rnd_latency: got %b want 1", c_out_valid); end
      end
      if (c_out_valid && c_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_spurious: got %h want no output", c_out_data);
        end else begin
          e = q.pop_front();
          recv++;
          if (c_out_data !== e) begin errors++; $display("FAIL rnd_data: got %h want %h", c_out_data, e); end
        end
      end
      fire = c_in_valid && c_in_ready;
      if (fire) begin
        q.push_back(sub_state(d, iv));
        sent++;
        d  = {$urandom(), $urandom(), $urandom(), $urandom()};
        iv = 1'($urandom_range(0, 1));
      end
      hist = {hist[0], fire};
      @(posedge clk); #1;
      cyc++;
    end
    c_in_valid = 0;
    checks++;
    if (sent != 1000 || recv != 1000 || q.size() != 0) begin
      errors++; $display("FAIL rnd_count: got sent=%0d recv=%0d left=%0d want 1000/1000/0", sent, recv, q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    build_model();
    test_reset();
    test_fwd_zero();
    test_fwd_vector();
    test_inv();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
